// File: rtl/led_seg7_scan_driver.sv
// Eight-digit hex seven-segment scan driver for the APB LED value register.
// Per-frame snapshot, dark interval at every digit change, optional leading-zero blanking.
module led_seg7_scan_driver #(
  parameter int CLK_DIV    = 50000,
  parameter int BLANK      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] ledNumIn,
  input  logic [7:0]  dp_en,
  input  logic        lzb_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_start
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

  logic [CW-1:0] div_cnt_r;
  logic [2:0]    dig_r;
  logic [31:0]   snap_val_r;
  logic [7:0]    snap_dp_r;
  logic          snap_lzb_r;
  logic          started_r;
  logic [7:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;
  logic          frame_start_r;

  logic          slot_end_s;
  logic          frame_end_s;
  logic [3:0]    nib_s;
  logic [31:0]   upper_s;
  logic          lzb_hide_s;
  logic [7:0]    an_s;
  logic [6:0]    seg_s;
  logic          dp_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      4'hF: code = 7'h71;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  // Slot and frame boundary detection
  always_comb begin
    slot_end_s  = (div_cnt_r == DIV_MAX);
    frame_end_s = slot_end_s && (dig_r == 3'd7);
  end

  // Active-high digit rendering from the current scan state and snapshot
  always_comb begin
    nib_s      = snap_val_r[{dig_r, 2'b00} +: 4];
    upper_s    = snap_val_r >> {dig_r, 2'b00};
    lzb_hide_s = snap_lzb_r && (dig_r != 3'd0) && (upper_s == 32'h0000_0000);
    an_s       = 8'h00;
    seg_s      = 7'h00;
    dp_s       = 1'b0;
    if ((div_cnt_r >= BLANK_C) && !lzb_hide_s) begin
      an_s  = 8'h01 << dig_r;
      seg_s = hex_to_seg(nib_s);
      dp_s  = snap_dp_r[dig_r];
    end else begin
      an_s  = 8'h00;
      seg_s = 7'h00;
      dp_s  = 1'b0;
    end
  end

  // Divider, digit index and frame snapshot; the snapshot reloads on the 7->0 wrap
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      div_cnt_r  <= '0;
      dig_r      <= 3'd0;
      snap_val_r <= 32'h0000_0000;
      snap_dp_r  <= 8'h00;
      snap_lzb_r <= 1'b0;
      started_r  <= 1'b0;
    end else begin
      if (slot_end_s) begin
        div_cnt_r <= '0;
        dig_r     <= dig_r + 3'd1;
      end else begin
        div_cnt_r <= div_cnt_r + CW'(1'b1);
      end
      if (frame_end_s) begin
        snap_val_r <= ledNumIn;
        snap_dp_r  <= dp_en;
        snap_lzb_r <= lzb_en;
        started_r  <= 1'b1;
      end
    end
  end

  // Registered pin drivers; the frame pulse is withheld for the frame entered from reset
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      an_r          <= {8{ACTIVE_LOW}};
      seg_r         <= {7{ACTIVE_LOW}};
      dp_r          <= ACTIVE_LOW;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_s ^ {8{ACTIVE_LOW}};
      seg_r         <= seg_s ^ {7{ACTIVE_LOW}};
      dp_r          <= dp_s ^ ACTIVE_LOW;
      frame_start_r <= started_r && (dig_r == 3'd0) && (div_cnt_r == '0);
    end
  end

  assign an          = an_r;
  assign seg         = seg_r;
  assign dp          = dp_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_led_seg7_scan_driver.sv
// Self-checking bench for led_seg7_scan_driver: directed scenarios plus random
// inputs, every output cycle compared against a frame/slot arithmetic model.
module tb_led_seg7_scan_driver;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 1;
  localparam int FRAME   = 8 * CLK_DIV;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] led_num;
  logic [7:0]  dp_en;
  logic        lzb_en;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;
  logic        frame_start;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  int fs_cnt = 0;

  // snapshot the model believes is in force for the state after edge n
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic        m_lzb;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_fs;

  logic [6:0] hex_code [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  led_seg7_scan_driver #(
    .CLK_DIV   (CLK_DIV),
    .BLANK     (BLANK),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .ledNumIn   (led_num),
    .dp_en      (dp_en),
    .lzb_en     (lzb_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_an"}, {24'h0, an}, 32'hFF);
    check({tag, "_seg"}, {25'h0, seg}, 32'h7F);
    check({tag, "_dp"}, {31'h0, dp}, 32'h1);
    check({tag, "_fs"}, {31'h0, frame_start}, 32'h0);
  endtask

  // Expected pins after edge n: they show the scan position n-1 of the frame
  task automatic model_outputs();
    int  pos;
    int  d;
    int  ph;
    logic lit;
    pos = (n - 1) % FRAME;
    d   = pos / CLK_DIV;
    ph  = pos % CLK_DIV;
    lit = (ph >= BLANK) && !(m_lzb && (d >= 1) && ((m_val >> (4 * d)) == 32'h0));
    e_an  = lit ? ~(8'h01 << d) : 8'hFF;
    e_seg = lit ? ~hex_code[m_val[4*d +: 4]] : 7'h7F;
    e_dp  = lit ? ~m_dp[d] : 1'b1;
    e_fs  = (pos == 0) && ((n - 1) >= FRAME);
  endtask

  task automatic step();
    @(posedge pclk);
    n++;
    model_outputs();
    if ((n % FRAME) == 0) begin
      m_val = led_num;
      m_dp  = dp_en;
      m_lzb = lzb_en;
    end
    #1;
    check("an", {24'h0, an}, {24'h0, e_an});
    check("seg", {25'h0, seg}, {25'h0, e_seg});
    check("dp", {31'h0, dp}, {31'h0, e_dp});
    check("frame_start", {31'h0, frame_start}, {31'h0, e_fs});
    if (frame_start === 1'b1) fs_cnt++;
  endtask

  // Step at least once, until the pins show frame position target
  task automatic run_to(input int target);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (((n - 1) % FRAME) == target) begin
        hit = 1'b1;
        break;
      end
    end
    check("run_to_bound", {31'h0, hit}, 32'h1);
  endtask

  task automatic release_reset();
    @(negedge pclk);
    presetn = 1'b1;
    n     = 0;
    m_val = 32'h0;
    m_dp  = 8'h0;
    m_lzb = 1'b0;
  endtask

  initial begin
    presetn = 1'b0;
    led_num = 32'h0;
    dp_en   = 8'h00;
    lzb_en  = 1'b0;
    m_val   = 32'h0;
    m_dp    = 8'h0;
    m_lzb   = 1'b0;

    // reset hold
    repeat (3) begin
      @(negedge pclk);
      check_idle("reset");
    end
    release_reset();

    // first frame shows zeros; hex decode of two values
    led_num = 32'h0123_4567;
    run_to(1);
    check("zero_d0_seg", {25'h0, seg}, 32'h40);
    check("zero_d0_an", {24'h0, an}, 32'hFE);
    run_to(1);
    check("hex1_d0", {25'h0, seg}, 32'h78);
    run_to(29);
    check("hex1_d7", {25'h0, seg}, 32'h40);
    check("hex1_d7_an", {24'h0, an}, 32'h7F);
    led_num = 32'h89AB_CDEF;
    run_to(1);
    check("hex2_d0", {25'h0, seg}, 32'h0E);
    run_to(29);
    check("hex2_d7", {25'h0, seg}, 32'h00);

    // tearing guard: change while digit 3 is on screen
    led_num = 32'h1111_1111;
    run_to(13);
    led_num = 32'h2222_2222;
    run_to(29);
    check("tear_old_d7", {25'h0, seg}, 32'h79);
    run_to(1);
    check("tear_new_d0", {25'h0, seg}, 32'h24);
    run_to(29);
    check("tear_new_d7", {25'h0, seg}, 32'h24);

    // leading-zero blanking
    lzb_en  = 1'b1;
    led_num = 32'h0000_0A05;
    run_to(31);
    run_to(9);
    check("lzb_d2_seg", {25'h0, seg}, 32'h08);
    run_to(13);
    check("lzb_d3_an", {24'h0, an}, 32'hFF);
    led_num = 32'h0;
    run_to(31);
    run_to(1);
    check("lzb0_d0_seg", {25'h0, seg}, 32'h40);
    run_to(5);
    check("lzb0_d1_an", {24'h0, an}, 32'hFF);

    // decimal points and frame pulse period
    lzb_en  = 1'b0;
    dp_en   = 8'h81;
    led_num = 32'hDEAD_BEEF;
    run_to(31);
    run_to(1);
    check("dp_d0", {31'h0, dp}, 32'h0);
    run_to(29);
    check("dp_d7", {31'h0, dp}, 32'h0);
    run_to(31);
    fs_cnt = 0;
    repeat (3 * FRAME) step();
    check("fs_count", fs_cnt, 32'd3);

    // random inputs changing at arbitrary points of the frame
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        led_num = $urandom;
        dp_en   = 8'($urandom);
        lzb_en  = 1'($urandom);
        if ($urandom_range(0, 3) == 0) led_num = led_num >> (4 * $urandom_range(1, 7));
      end
      step();
    end

    // asynchronous reset while digit 5 is lit
    lzb_en  = 1'b0;
    led_num = 32'h7654_3210;
    run_to(31);
    run_to(21);
    #2;
    presetn = 1'b0;
    #1;
    check_idle("midreset");
    repeat (2) begin
      @(negedge pclk);
      check_idle("midreset_hold");
    end
    release_reset();
    led_num = $urandom;
    dp_en   = 8'($urandom);
    run_to(21);
    check("post_reset_d5", {25'h0, seg}, 32'h40);
    repeat (2 * FRAME) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
